// File: rtl/sha256_sigma_pipe.sv
// Pipelined SHA-256 sigma unit: one of Σ0/Σ1/σ0/σ1 per word, selected by in_mode,
// with elastic valid/ready stages that compress bubbles and carry a caller tag.
module sha256_sigma_pipe #(
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  if (STAGES < 1 || STAGES > 3) begin : g_bad_stages
    $error("sha256_sigma_pipe: STAGES must be 1, 2 or 3");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("sha256_sigma_pipe: TAG_W must be at least 1");
  end

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Packed as {t0, t1, t2}; the last term of σ0/σ1 is a plain shift.
  function automatic logic [95:0] sel_terms(input logic [31:0] x, input logic [1:0] mode);
    logic [95:0] t;
    case (mode)
      2'd0:    t = {rotr(x, 2),  rotr(x, 13), rotr(x, 22)};
      2'd1:    t = {rotr(x, 6),  rotr(x, 11), rotr(x, 25)};
      2'd2:    t = {rotr(x, 7),  rotr(x, 18), x >> 3};
      default: t = {rotr(x, 17), rotr(x, 19), x >> 10};
    endcase
    return t;
  endfunction

  function automatic logic [31:0] xor3(input logic [95:0] t);
    return t[95:64] ^ t[63:32] ^ t[31:0];
  endfunction

  logic [STAGES:1] v;
  logic [STAGES:1] stage_ready;
  logic [STAGES:1] fill;
  logic [STAGES:1] load;

  // A stage can take data when it or any later stage is empty, or the output drains.
  for (genvar k = 1; k <= STAGES; k++) begin : g_ctl
    assign stage_ready[k] = out_ready | ~(&v[STAGES:k]);
    if (k == 1) begin : g_first
      assign fill[k] = in_valid;
    end else begin : g_rest
      assign fill[k] = v[k-1];
    end
  end

  assign load      = stage_ready & fill;
  assign in_ready  = stage_ready[1];
  assign out_valid = v[STAGES];
  assign busy      = |v;

  always_ff @(posedge clock) begin
    if (reset) begin
      v <= '0;
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (stage_ready[k]) begin
          v[k] <= fill[k];
        end
      end
    end
  end

  if (STAGES == 1) begin : g_s1
    logic [31:0]      d1;
    logic [TAG_W-1:0] tag1;

    always_ff @(posedge clock) begin
      if (reset) begin
        d1   <= '0;
        tag1 <= '0;
      end else if (load[1]) begin
        d1   <= xor3(sel_terms(in_data, in_mode));
        tag1 <= in_tag;
      end
    end

    assign out_data = d1;
    assign out_tag  = tag1;
  end else if (STAGES == 2) begin : g_s2
    logic [95:0]      terms1;
    logic [TAG_W-1:0] tag1;
    logic [31:0]      d2;
    logic [TAG_W-1:0] tag2;

    always_ff @(posedge clock) begin
      if (reset) begin
        terms1 <= '0;
        tag1   <= '0;
        d2     <= '0;
        tag2   <= '0;
      end else begin
        if (load[1]) begin
          terms1 <= sel_terms(in_data, in_mode);
          tag1   <= in_tag;
        end
        if (load[2]) begin
          d2   <= xor3(terms1);
          tag2 <= tag1;
        end
      end
    end

    assign out_data = d2;
    assign out_tag  = tag2;
  end else begin : g_s3
    logic [31:0]      x1;
    logic [1:0]       mode1;
    logic [TAG_W-1:0] tag1;
    logic [95:0]      terms2;
    logic [TAG_W-1:0] tag2;
    logic [31:0]      d3;
    logic [TAG_W-1:0] tag3;

    // Mode travels with its word so later in_mode changes cannot affect it.
    always_ff @(posedge clock) begin
      if (reset) begin
        x1     <= '0;
        mode1  <= '0;
        tag1   <= '0;
        terms2 <= '0;
        tag2   <= '0;
        d3     <= '0;
        tag3   <= '0;
      end else begin
        if (load[1]) begin
          x1    <= in_data;
          mode1 <= in_mode;
          tag1  <= in_tag;
        end
        if (load[2]) begin
          terms2 <= sel_terms(x1, mode1);
          tag2   <= tag1;
        end
        if (load[3]) begin
          d3   <= xor3(terms2);
          tag3 <= tag2;
        end
      end
    end

    assign out_data = d3;
    assign out_tag  = tag3;
  end

endmodule
